rect_pos_ctl: RTL and testbench

- Frame-synchronous position controller feeding xpos/ypos into the rectangle draw stage.
- Follows the mouse, clamped to the visible area.
- A left click drops the rectangle under gravity to the screen floor. A second click returns it to mouse-follow.
- All position updates occur once per frame, at vblank start, so the draw stage never tears mid-frame.

---
 rtl/rect_pos_ctl.sv | 206 ++++++++++++++++++++
 tb/tb_rect_pos_ctl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_pos_ctl.sv
// ---------------------------------------------------------------------------
// rect_pos_ctl
//
// Purpose:
//   Frame-synchronous position controller for the rectangle draw stage.
//   In FOLLOW the rectangle tracks the mouse, clamped so it stays fully
//   visible. A left click drops it under gravity to the screen floor
//   (FALL -> LANDED). Another click returns it to mouse-follow. xpos, ypos,
//   velocity and state change only on the frame tick at vblank start, so the
//   draw stage never sees a position change partway through a frame.
//
// Optional feature:
//   RECT_BOUNCE_EN - when defined, a floor impact at or above BOUNCE_MIN
//   px/frame bounces the rectangle up (RISE) at half the impact speed. The
//   BOUNCE_MIN parameter exists only in that build.
//
// Ports:
//   pclk        in   1   pixel clock, rising edge
//   rst         in   1   synchronous reset, active low
//   mouse_xpos  in  12   raw mouse x
//   mouse_ypos  in  12   raw mouse y
//   mouse_left  in   1   left button level (pclk domain)
//   vblnk_in    in   1   vertical blank from the timing generator
//   xpos        out 12   rectangle left edge
//   ypos        out 12   rectangle top edge
//   state_out   out  2   debug: FOLLOW=0, FALL=1, LANDED=2, RISE=3
// ---------------------------------------------------------------------------
module rect_pos_ctl #(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned V_ACTIVE    = 600,
    parameter int unsigned RECT_WIDTH  = 64,
    parameter int unsigned RECT_HEIGHT = 64,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned VMAX        = 32
`ifdef RECT_BOUNCE_EN
    ,
    parameter int unsigned BOUNCE_MIN  = 4
`endif
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        vblnk_in,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        LANDED = 2'd2,
        RISE   = 2'd3
    } state_t;

    localparam logic [11:0] XMAX   = 12'(H_ACTIVE - RECT_WIDTH);
    localparam logic [11:0] FLOOR  = 12'(V_ACTIVE - RECT_HEIGHT);
    localparam logic [5:0]  GRAV6  = 6'(GRAVITY);
    localparam logic [5:0]  VMAX6  = 6'(VMAX);
`ifdef RECT_BOUNCE_EN
    localparam logic [5:0]  BMIN6  = 6'(BOUNCE_MIN);
`endif

    // Registered state
    logic        r_vblnk_d;
    logic        r_armed;
    logic        r_left_d;
    logic        r_click_pend;
    state_t      r_state;
    logic [11:0] r_xpos;
    logic [11:0] r_ypos;
    logic [5:0]  r_vel;

    // Combinational
    logic        w_tick;
    logic        w_click_edge;
    logic        w_click;
    logic [11:0] w_x_clamp;
    logic [11:0] w_y_clamp;
    logic [6:0]  w_vel_sum;
    logic [5:0]  w_vel_inc;
    logic [12:0] w_y_drop;
`ifdef RECT_BOUNCE_EN
    logic [11:0] w_y_rise;
    logic [5:0]  w_vel_dec;
`endif
    state_t      w_state_next;
    logic [11:0] w_xpos_next;
    logic [11:0] w_ypos_next;
    logic [5:0]  w_vel_next;

    // r_armed stays low until vblnk_in has been seen low after reset, so a
    // vblank that is already high when reset releases does not tick.
    assign w_tick       = vblnk_in & ~r_vblnk_d & r_armed;
    assign w_click_edge = mouse_left & ~r_left_d;
    // An edge on the tick cycle is consumed by that tick directly.
    assign w_click      = r_click_pend | w_click_edge;

    assign w_x_clamp = (mouse_xpos > XMAX)  ? XMAX  : mouse_xpos;
    assign w_y_clamp = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;

    // Velocity update saturates at VMAX; carry kept in bit 6.
    assign w_vel_sum = {1'b0, r_vel} + {1'b0, GRAV6};
    assign w_vel_inc = (w_vel_sum > {1'b0, VMAX6}) ? VMAX6 : w_vel_sum[5:0];
    // 13-bit sum so a fast fall near the bottom cannot wrap past the floor.
    assign w_y_drop  = {1'b0, r_ypos} + {7'b0, w_vel_inc};

`ifdef RECT_BOUNCE_EN
    assign w_y_rise  = (r_ypos > {6'b0, r_vel}) ? (r_ypos - {6'b0, r_vel}) : '0;
    assign w_vel_dec = (r_vel > GRAV6) ? (r_vel - GRAV6) : '0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_xpos_next  = r_xpos;
        w_ypos_next  = r_ypos;
        w_vel_next   = r_vel;
        if (w_tick) begin
            case (r_state)
                FOLLOW: begin
                    w_xpos_next = w_x_clamp;
                    w_ypos_next = w_y_clamp;
                    if (w_click) begin
                        w_vel_next   = '0;
                        w_state_next = FALL;
                    end
                end
                FALL: begin
                    if (w_y_drop >= {1'b0, FLOOR}) begin
                        w_ypos_next = FLOOR;
`ifdef RECT_BOUNCE_EN
                        if (w_vel_inc >= BMIN6) begin
                            w_vel_next   = w_vel_inc >> 1;
                            w_state_next = RISE;
                        end else begin
                            w_vel_next   = '0;
                            w_state_next = LANDED;
                        end
`else
                        w_vel_next   = '0;
                        w_state_next = LANDED;
`endif
                    end else begin
                        w_ypos_next = w_y_drop[11:0];
                        w_vel_next  = w_vel_inc;
                    end
                end
                LANDED: begin
                    // Mouse position is picked up on the following tick.
                    if (w_click) begin
                        w_state_next = FOLLOW;
                    end
                end
                RISE: begin
`ifdef RECT_BOUNCE_EN
                    w_ypos_next = w_y_rise;
                    w_vel_next  = w_vel_dec;
                    if (w_vel_dec == '0) begin
                        w_state_next = FALL;
                    end
`else
                    w_state_next = FOLLOW;
`endif
                end
                default: begin
                    w_state_next = FOLLOW;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_vblnk_d    <= 1'b0;
            r_armed      <= 1'b0;
            r_left_d     <= 1'b0;
            r_click_pend <= 1'b0;
            r_state      <= FOLLOW;
            r_xpos       <= '0;
            r_ypos       <= '0;
            r_vel        <= '0;
        end else begin
            r_vblnk_d <= vblnk_in;
            r_armed   <= r_armed | ~vblnk_in;
            r_left_d  <= mouse_left;
            // Clicks collapse into one pending flag, consumed at every tick
            // whether or not the current state acts on it.
            if (w_tick) begin
                r_click_pend <= 1'b0;
            end else if (w_click_edge) begin
                r_click_pend <= 1'b1;
            end
            r_state <= w_state_next;
            r_xpos  <= w_xpos_next;
            r_ypos  <= w_ypos_next;
            r_vel   <= w_vel_next;
        end
    end

    assign xpos      = r_xpos;
    assign ypos      = r_ypos;
    assign state_out = r_state;

endmodule

// File: tb/tb_rect_pos_ctl.sv
module tb_rect_pos_ctl;

    // Spec constants for the default parameter set
    localparam int XMAX  = 736;
    localparam int FLOOR = 536;
    localparam int GRAV  = 1;
    localparam int VMAXV = 32;
    localparam int BMIN  = 4;

    localparam int S_FOLLOW = 0;
    localparam int S_FALL   = 1;
    localparam int S_LANDED = 2;
    localparam int S_RISE   = 3;

    logic        pclk       = 1'b0;
    logic        rst        = 1'b0;
    logic        vblnk_in   = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic        probe      = 1'b0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [1:0]  state_out;

    always #5 pclk = ~pclk;

    rect_pos_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .vblnk_in   (vblnk_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .state_out  (state_out)
    );

    typedef struct {
        int x;
        int y;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int   m_x = 0, m_y = 0, m_vel = 0, m_st = S_FOLLOW;
    bit   m_pend = 0, m_armed = 0;
    logic m_prevl = 1'b0, m_prevv = 1'b0;
    int   cur_x = 0, cur_y = 0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // One frame of behaviour, straight from the rules
    function automatic void model_tick(bit click);
        int vn;
        case (m_st)
            S_FOLLOW: begin
                m_x = imin(cur_x, XMAX);
                m_y = imin(cur_y, FLOOR);
                if (click) begin
                    m_vel = 0;
                    m_st  = S_FALL;
                end
            end
            S_FALL: begin
                vn = imin(m_vel + GRAV, VMAXV);
                if (m_y + vn >= FLOOR) begin
                    m_y = FLOOR;
`ifdef RECT_BOUNCE_EN
                    if (vn >= BMIN) begin
                        m_vel = vn / 2;
                        m_st  = S_RISE;
                    end else begin
                        m_vel = 0;
                        m_st  = S_LANDED;
                    end
`else
                    m_vel = 0;
                    m_st  = S_LANDED;
`endif
                end else begin
                    m_y   = m_y + vn;
                    m_vel = vn;
                end
            end
            S_LANDED: begin
                if (click) m_st = S_FOLLOW;
            end
            default: begin
`ifdef RECT_BOUNCE_EN
                m_y   = imax(m_y - m_vel, 0);
                m_vel = imax(m_vel - GRAV, 0);
                if (m_vel == 0) m_st = S_FALL;
`else
                m_st = S_FOLLOW;
`endif
            end
        endcase
    endfunction

    // Drive one cycle of inputs and advance the model for the coming edge
    task automatic cyc(input logic r, input logic v, input logic l, input bit pb);
        @(negedge pclk);
        rst        = r;
        vblnk_in   = v;
        mouse_left = l;
        mouse_xpos = 12'(cur_x);
        mouse_ypos = 12'(cur_y);
        probe      = pb;
        if (!r) begin
            m_x = 0; m_y = 0; m_vel = 0; m_st = S_FOLLOW;
            m_pend  = 0;
            m_armed = 0;
            m_prevl = 1'b0;
        end else begin
            if (l && !m_prevl) m_pend = 1;
            if (v && !m_prevv && m_armed) begin
                model_tick(m_pend);
                m_pend = 0;
            end
            if (!v) m_armed = 1;
            m_prevl = l;
        end
        if ((v && !m_prevv) || pb) exp_q.push_back('{m_x, m_y, m_st});
        m_prevv = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic click();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic probe_chk();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: outputs are presented one clock after each vblank rise, and
    // at explicit probe points; each presentation pops one expectation.
    logic mon_prev = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(posedge pclk);
            #1;
            if ((vblnk_in && !mon_prev) || probe) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: no expectation queued at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (xpos !== 12'(e.x)) begin
                        bad++;
                        $display("FAIL xpos: got=%0d want=%0d t=%0t", xpos, e.x, $time);
                    end
                    total++;
                    if (ypos !== 12'(e.y)) begin
                        bad++;
                        $display("FAIL ypos: got=%0d want=%0d t=%0t", ypos, e.y, $time);
                    end
                    total++;
                    if (state_out !== 2'(e.st)) begin
                        bad++;
                        $display("FAIL state: got=%0d want=%0d t=%0t", state_out, e.st, $time);
                    end
                end
            end
            mon_prev = vblnk_in;
        end
    end

    initial begin
        // Reset with mouse parked
        cur_x = 300; cur_y = 200;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        tick();

        // Clamp, and no update mid-frame
        cur_x = 790; cur_y = 590;
        idle(2); tick();
        cur_x = 10; cur_y = 20;
        idle(2); probe_chk();
        idle(1); tick();

        // Drop from 500, with a click during the fall
        cur_x = 100; cur_y = 500;
        tick();
        click(); idle(1); tick();
        tick(); tick();
        click();
        for (int i = 0; i < 8; i++) tick();

        // Two clicks in one frame while landed, then mouse pickup next tick
        click(); click(); tick();
        cur_x = 50; cur_y = 60;
        tick();

        // Click edge coincident with the tick edge
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) tick();

        // Long fall from the top
        click(); tick();
        cur_x = 0; cur_y = 0;
        click(); tick();
        for (int i = 0; i < 45; i++) tick();

        // Reset mid-fall
        click(); tick();
        cur_y = 100;
        click(); tick();
        tick(); tick(); tick();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // vblank already high across reset release: no tick until it re-rises
        cur_x = 400; cur_y = 300;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        idle(2); tick();

        // Randomized frames
        for (int f = 0; f < 300; f++) begin
            int lo, hi;
            logic l;
            lo = int'($urandom_range(2, 8));
            hi = int'($urandom_range(1, 4));
            if ($urandom_range(0, 49) == 0) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b1);
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
            end
            for (int i = 0; i < lo; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        cur_x = int'($urandom_range(0, 4095));
                        cur_y = int'($urandom_range(0, 4095));
                    end else begin
                        cur_x = int'($urandom_range(0, 900));
                        cur_y = int'($urandom_range(0, 700));
                    end
                end
                l = ($urandom_range(0, 4) == 0);
                cyc(1'b1, 1'b0, l, 1'b0);
            end
            for (int i = 0; i < hi; i++) begin
                l = ($urandom_range(0, 4) == 0);
                cyc(1'b1, 1'b1, l, 1'b0);
            end
        end
        idle(5);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d leftover expectations want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
